// File: rtl/blft_pkg.sv
// Shared constants, FSM state type and address helpers for the bilateral-filter image feeder.
package blft_pkg;

    localparam int unsigned IMG_W = 256;
    localparam int unsigned IMG_H = 256;
    localparam int unsigned AW    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE
    } feeder_state_t;

    function automatic logic [7:0] addr_row(input logic [15:0] addr);
        return addr[15:8];
    endfunction

    function automatic logic [7:0] addr_col(input logic [15:0] addr);
        return addr[7:0];
    endfunction

endpackage

// File: rtl/blft_frame_ram.sv
// Single-port frame memory, 2^AW x 8, synchronous write and registered synchronous read.
module blft_frame_ram #(
    parameter int unsigned AW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    localparam int unsigned Depth = 1 << AW;

    logic [7:0] r_mem [Depth];
    logic [7:0] r_rdata;

    // Storage is never reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= 8'h00;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/blft_img_feeder.sv
// Frame loader and random-access pixel server for the bilateral filter.
// Optional frame checksum enabled by defining BLFT_FEEDER_CKSUM_EN.
module blft_img_feeder
    import blft_pkg::*;
#(
    parameter int unsigned IMG_W = blft_pkg::IMG_W,
    parameter int unsigned IMG_H = blft_pkg::IMG_H,
    parameter int unsigned AW    = blft_pkg::AW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    input  logic [7:0]    i_s_data,
    input  logic          i_s_last,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic          o_rd_valid,
    input  logic          i_finish,
    output logic          o_load_done,
    output logic          o_frame_err,
    output logic [15:0]   o_cksum
);

    localparam logic [AW-1:0] LastIdx = AW'(IMG_W * IMG_H - 1);

    feeder_state_t r_state;
    logic [AW-1:0] r_wr_cnt;
    logic [AW-1:0] r_addr_q;
    logic          r_aq_vld;
    logic          r_frame_err;

    logic          w_accept;
    logic          w_serve;
    logic          w_cnt_max;
    logic [AW-1:0] w_ram_addr;

    assign w_serve    = (r_state == SERVE);
    assign w_accept   = (r_state == LOAD) && i_s_valid;
    assign w_cnt_max  = (r_wr_cnt == LastIdx);
    // Writes only happen in LOAD and reads only in SERVE, so one port suffices.
    assign w_ram_addr = w_serve ? i_rd_addr : r_wr_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_wr_cnt    <= '0;
            r_addr_q    <= '0;
            r_aq_vld    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_aq_vld <= 1'b0;
                    if (i_start) begin
                        r_state     <= LOAD;
                        r_wr_cnt    <= '0;
                        r_frame_err <= 1'b0;
                    end
                end
                LOAD: begin
                    r_aq_vld <= 1'b0;
                    if (w_accept) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                        if (i_s_last && w_cnt_max) begin
                            r_state <= SERVE;
                        end else if (i_s_last || w_cnt_max) begin
                            r_frame_err <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                SERVE: begin
                    r_addr_q <= i_rd_addr;
                    r_aq_vld <= ~i_finish;
                    if (i_finish) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BLFT_FEEDER_CKSUM_EN
    logic [15:0] r_cksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cksum <= 16'h0000;
        end else if ((r_state == IDLE) && i_start) begin
            r_cksum <= 16'h0000;
        end else if (w_accept) begin
            r_cksum <= r_cksum + {8'h00, i_s_data};
        end
    end

    assign o_cksum = r_cksum;
`else
    assign o_cksum = 16'h0000;
`endif

    blft_frame_ram #(
        .AW(AW)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_accept),
        .i_re   (w_serve),
        .i_addr (w_ram_addr),
        .i_wdata(i_s_data),
        .o_rdata(o_rd_data)
    );

    assign o_s_ready   = (r_state == LOAD);
    assign o_load_done = w_serve;
    assign o_frame_err = r_frame_err;
    // Valid only once the address has been held across an edge.
    assign o_rd_valid  = w_serve && r_aq_vld && (i_rd_addr == r_addr_q);

endmodule

// File: tb/tb_blft_img_feeder.sv
// Scoreboard bench for blft_img_feeder: expected reads are queued, a monitor pops on rd_valid.
module tb_blft_img_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        finish;
    logic        load_done;
    logic        frame_err;
    logic [15:0] cksum;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    blft_img_feeder u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_s_valid  (s_valid),
        .o_s_ready  (s_ready),
        .i_s_data   (s_data),
        .i_s_last   (s_last),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_finish   (finish),
        .o_load_done(load_done),
        .o_frame_err(frame_err),
        .o_cksum    (cksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid read must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: addr 0x%04h data 0x%02h, none expected",
                         rd_addr, rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rd_addr@0x%04h", e.addr), 32'(rd_addr), 32'(e.addr));
                check($sformatf("rd_data@0x%04h", e.addr), 32'(rd_data), 32'(e.data));
            end
        end
    end

    function automatic logic [7:0] ramp(input int i);
        return 8'(((i >> 8) + (i & 255)) & 255);
    endfunction

    // ramp_mode=1: ramp pixels with random host gaps; 0: gap-free 0xA5^index pattern.
    task automatic send_beats(input int n, input int last_at, input bit ramp_mode);
        for (int i = 0; i < n; i++) begin
            if (ramp_mode) begin
                while ($urandom_range(7) == 0) begin
                    s_valid = 1'b0;
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data  = ramp_mode ? ramp(i) : (8'hA5 ^ 8'(i));
            s_last  = (i == last_at);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Hold an address for `cycles`, queueing `nvalid` expected reads of `data`.
    task automatic hold(input logic [15:0] a, input int cycles, input int nvalid,
                        input logic [7:0] data);
        exp_t e;
        rd_addr = a;
        e.addr  = a;
        e.data  = data;
        for (int k = 0; k < nvalid; k++) exp_q.push_back(e);
        repeat (cycles) tick();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] steps [6];
        steps[0] = 16'h0000; steps[1] = 16'h0001; steps[2] = 16'h0002;
        steps[3] = 16'h00FF; steps[4] = 16'hFFFF; steps[5] = 16'h8040;

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        rd_addr = 16'h0000; finish = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_cksum", 32'(cksum), 32'd0);
        rst = 1'b0;
        tick();

        // Early s_last on beat 100.
        pulse_start();
        @(negedge clk);
        check("start_s_ready", 32'(s_ready), 32'd1);
        send_beats(101, 100, 1'b0);
        @(negedge clk);
        check("early_last_frame_err", 32'(frame_err), 32'd1);
        check("early_last_idle", 32'(s_ready), 32'd0);
        check("early_last_load_done", 32'(load_done), 32'd0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        @(negedge clk);
        check("finish_in_idle_ignored", 32'(frame_err), 32'd1);

        // Restart clears the error, then reset mid-load abandons the frame.
        pulse_start();
        @(negedge clk);
        check("restart_clears_err", 32'(frame_err), 32'd0);
        check("restart_s_ready", 32'(s_ready), 32'd1);
        send_beats(300, -1, 1'b0);
        rst     = 1'b1;
        s_valid = 1'b1;
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("midload_rst_s_ready", 32'(s_ready), 32'd0);
        check("midload_rst_load_done", 32'(load_done), 32'd0);
        check("midload_rst_frame_err", 32'(frame_err), 32'd0);
        check("midload_rst_cksum", 32'(cksum), 32'd0);
        check("midload_rst_rd_data", 32'(rd_data), 32'd0);

        // Full ramp frame with host back-pressure.
        pulse_start();
        send_beats(65536, 65535, 1'b1);
        @(negedge clk);
        check("full_load_done", 32'(load_done), 32'd1);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_frame_err", 32'(frame_err), 32'd0);
        check("first_serve_rd_valid", 32'(rd_valid), 32'd0);
`ifdef BLFT_FEEDER_CKSUM_EN
        check("ramp_cksum", 32'(cksum), 32'h8000);
`else
        check("ramp_cksum", 32'(cksum), 32'h0000);
`endif
        tick();

        // 0x0203 -> 2+3 = 0x05; four-cycle hold gives three valid cycles.
        hold(16'h0203, 4, 3, 8'h05);
        for (int s = 0; s < 6; s++) begin
            hold(steps[s], 2, 1, ramp(int'(steps[s])));
        end
        hold(16'h0A0B, 3, 2, 8'h15);

        // finish on the first cycle of a new address, so no valid is owed.
        rd_addr = 16'h0300;
        finish  = 1'b1;
        tick();
        finish  = 1'b0;
        @(negedge clk);
        check("finish_rd_valid", 32'(rd_valid), 32'd0);
        check("finish_load_done", 32'(load_done), 32'd0);
        check("finish_s_ready", 32'(s_ready), 32'd0);
        check("finish_keeps_err_clear", 32'(frame_err), 32'd0);
        tick();

        // New load: finish and start are both ignored in LOAD.
        pulse_start();
        finish = 1'b1;
        start  = 1'b1;
        tick();
        finish = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        check("finish_in_load_ignored", 32'(s_ready), 32'd1);
        check("load_not_done", 32'(load_done), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
